// File: rtl/thread_regfile_sb.sv
// Per-thread register file with pending-load scoreboard, memory-return write port and read-only guard.
// Reads registered (1 cycle); ld_done always accepted; stall tells the scheduler to re-issue REQUEST.

`ifndef CORE_REQUEST
`define CORE_REQUEST 3'b011
`endif
`ifndef CORE_WRITEBACK
`define CORE_WRITEBACK 3'b110
`endif

module thread_regfile_sb #(
    parameter int THREAD_ID  = 0,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 16,
    parameter int BLOCK_DIM  = 4,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] block_id,
    input  logic [2:0]            core_state,
    input  logic [AW-1:0]         rd_address,
    input  logic [AW-1:0]         rs_address,
    input  logic [AW-1:0]         rt_address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  RegWrite,
    input  logic                  ld_issue,
    input  logic                  ld_done,
    input  logic [AW-1:0]         ld_address,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [DATA_WIDTH-1:0] rs,
    output logic [DATA_WIDTH-1:0] rt,
    output logic                  stall,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  ro_write_err
);

    localparam int NFREE = NUM_REGS - 3;
    localparam logic [AW-1:0]         L_NFREE = AW'(NFREE);
    localparam logic [AW-1:0]         L_BIDX  = AW'(NUM_REGS - 3);
    localparam logic [AW-1:0]         L_BDIM  = AW'(NUM_REGS - 2);
    localparam logic [AW-1:0]         L_TIDX  = AW'(NUM_REGS - 1);
    localparam logic [DATA_WIDTH-1:0] L_TID_V = DATA_WIDTH'(THREAD_ID);
    localparam logic [DATA_WIDTH-1:0] L_BDM_V = DATA_WIDTH'(BLOCK_DIM);

    logic [DATA_WIDTH-1:0] r_free [NFREE];
    logic [NFREE-1:0]      r_pend;
    logic [DATA_WIDTH-1:0] r_block_idx;
    logic [DATA_WIDTH-1:0] r_rs;
    logic [DATA_WIDTH-1:0] r_rt;
    logic                  r_stall;
    logic                  r_ro_err;

    logic                  w_req;
    logic                  w_wb;
    logic                  w_rd_free;
    logic                  w_wb_free;
    logic                  w_iss_free;
    logic                  w_ld_free;
    logic                  w_ro_err;
    logic [NFREE-1:0]      w_ld_clr;
    logic [NFREE-1:0]      w_iss_set;
    logic [NFREE-1:0]      w_wb_sel;
    logic [DATA_WIDTH-1:0] w_rs_nxt;
    logic [DATA_WIDTH-1:0] w_rt_nxt;
    logic                  w_rs_pend;
    logic                  w_rt_pend;

    assign w_req      = enable && (core_state == `CORE_REQUEST);
    assign w_wb       = enable && (core_state == `CORE_WRITEBACK) && RegWrite;
    assign w_rd_free  = (rd_address < L_NFREE);
    assign w_wb_free  = w_wb && w_rd_free;
    assign w_iss_free = enable && ld_issue && w_rd_free;
    assign w_ld_free  = ld_done && (ld_address < L_NFREE);
    assign w_ro_err   = enable && !w_rd_free && (w_wb || ld_issue);

    always_comb begin
        w_ld_clr  = '0;
        w_iss_set = '0;
        w_wb_sel  = '0;
        for (int i = 0; i < NFREE; i++) begin
            w_ld_clr[i]  = w_ld_free  && (ld_address == AW'(i));
            w_iss_set[i] = w_iss_free && (rd_address == AW'(i));
            w_wb_sel[i]  = w_wb_free  && (rd_address == AW'(i));
        end
    end

    // A load landing this cycle both bypasses its data and retires its pending bit for the stall check.
    always_comb begin
        w_rs_nxt  = '0;
        w_rs_pend = 1'b0;
        for (int i = 0; i < NFREE; i++) begin
            if (rs_address == AW'(i)) begin
                w_rs_nxt  = r_free[i];
                w_rs_pend = r_pend[i] & ~w_ld_clr[i];
            end
        end
        if (rs_address == L_BIDX) w_rs_nxt = r_block_idx;
        if (rs_address == L_BDIM) w_rs_nxt = L_BDM_V;
        if (rs_address == L_TIDX) w_rs_nxt = L_TID_V;
        if (w_ld_free && (ld_address == rs_address)) w_rs_nxt = ld_data;
    end

    always_comb begin
        w_rt_nxt  = '0;
        w_rt_pend = 1'b0;
        for (int i = 0; i < NFREE; i++) begin
            if (rt_address == AW'(i)) begin
                w_rt_nxt  = r_free[i];
                w_rt_pend = r_pend[i] & ~w_ld_clr[i];
            end
        end
        if (rt_address == L_BIDX) w_rt_nxt = r_block_idx;
        if (rt_address == L_BDIM) w_rt_nxt = L_BDM_V;
        if (rt_address == L_TIDX) w_rt_nxt = L_TID_V;
        if (w_ld_free && (ld_address == rt_address)) w_rt_nxt = ld_data;
    end

    // Core writeback beats a same-address load return: it is younger in program order.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NFREE; i++) r_free[i] <= '0;
            r_pend      <= '0;
            r_block_idx <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_stall     <= 1'b0;
            r_ro_err    <= 1'b0;
        end else begin
            for (int i = 0; i < NFREE; i++) begin
                if (w_wb_sel[i])      r_free[i] <= WriteData;
                else if (w_ld_clr[i]) r_free[i] <= ld_data;
            end
            r_pend <= (r_pend & ~w_ld_clr) | w_iss_set;
            if (enable) r_block_idx <= block_id;
            if (w_req) begin
                r_rs    <= w_rs_nxt;
                r_rt    <= w_rt_nxt;
                r_stall <= w_rs_pend | w_rt_pend;
            end
            r_ro_err <= w_ro_err;
        end
    end

    assign rs           = r_rs;
    assign rt           = r_rt;
    assign stall        = r_stall;
    assign pending      = {3'b000, r_pend};
    assign ro_write_err = r_ro_err;

endmodule

// File: tb/tb_thread_regfile_sb.sv
// Directed-vector bench for thread_regfile_sb: narrow instance (THREAD_ID=2) plus a wide 16-bit/32-register instance.

`ifndef CORE_REQUEST
`define CORE_REQUEST 3'b011
`endif
`ifndef CORE_WRITEBACK
`define CORE_WRITEBACK 3'b110
`endif

module tb_thread_regfile_sb;

    localparam logic [2:0] ST_IDLE = 3'b000;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  block_id;
    logic [2:0]  core_state;
    logic [3:0]  rd_address, rs_address, rt_address, ld_address;
    logic [7:0]  WriteData, ld_data;
    logic        RegWrite, ld_issue, ld_done;
    logic [7:0]  rs, rt;
    logic        stall, ro_write_err;
    logic [15:0] pending;

    logic [15:0] block_id_w, WriteData_w, ld_data_w, rs_w_o, rt_w_o;
    logic [4:0]  rd_w, rs_w, rt_w, ld_addr_w;
    logic        RegWrite_w, ld_issue_w, ld_done_w, stall_w, ro_err_w;
    logic [31:0] pending_w;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    thread_regfile_sb #(.THREAD_ID(2), .DATA_WIDTH(8), .NUM_REGS(16), .BLOCK_DIM(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .block_id(block_id),
        .core_state(core_state), .rd_address(rd_address), .rs_address(rs_address),
        .rt_address(rt_address), .WriteData(WriteData), .RegWrite(RegWrite),
        .ld_issue(ld_issue), .ld_done(ld_done), .ld_address(ld_address),
        .ld_data(ld_data), .rs(rs), .rt(rt), .stall(stall), .pending(pending),
        .ro_write_err(ro_write_err)
    );

    thread_regfile_sb #(.THREAD_ID(300), .DATA_WIDTH(16), .NUM_REGS(32), .BLOCK_DIM(32'h0001_0005)) dut_w (
        .clk(clk), .reset(reset), .enable(enable), .block_id(block_id_w),
        .core_state(core_state), .rd_address(rd_w), .rs_address(rs_w),
        .rt_address(rt_w), .WriteData(WriteData_w), .RegWrite(RegWrite_w),
        .ld_issue(ld_issue_w), .ld_done(ld_done_w), .ld_address(ld_addr_w),
        .ld_data(ld_data_w), .rs(rs_w_o), .rt(rt_w_o), .stall(stall_w), .pending(pending_w),
        .ro_write_err(ro_err_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enable     = 1'b1;
        core_state = ST_IDLE;
        rd_address = '0; rs_address = '0; rt_address = '0; ld_address = '0;
        WriteData  = '0; ld_data = '0;
        RegWrite   = 1'b0; ld_issue = 1'b0; ld_done = 1'b0;
    endtask

    task automatic request(input logic [3:0] s, input logic [3:0] t);
        idle_inputs();
        core_state = `CORE_REQUEST;
        rs_address = s;
        rt_address = t;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        vectors++; if (rs !== 8'h00) begin errs++; $display("FAIL reset_rs got %h want 00", rs); end
        vectors++; if (rt !== 8'h00) begin errs++; $display("FAIL reset_rt got %h want 00", rt); end
        vectors++; if (stall !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", stall); end
        vectors++; if (pending !== 16'h0000) begin errs++; $display("FAIL reset_pending got %h want 0000", pending); end
        vectors++; if (ro_write_err !== 1'b0) begin errs++; $display("FAIL reset_roerr got %b want 0", ro_write_err); end
        reset = 1'b0;
    endtask

    task automatic test_special_regs();
        request(4'd15, 4'd14);
        vectors++; if (rs !== 8'h02) begin errs++; $display("FAIL tid_read got %h want 02", rs); end
        vectors++; if (rt !== 8'h04) begin errs++; $display("FAIL bdim_read got %h want 04", rt); end
        vectors++; if (stall !== 1'b0) begin errs++; $display("FAIL special_stall got %b want 0", stall); end
        vectors++; if (pending !== 16'h0000) begin errs++; $display("FAIL special_pending got %h want 0000", pending); end
        request(4'd13, 4'd0);
        vectors++; if (rs !== 8'h09) begin errs++; $display("FAIL bidx_read got %h want 09", rs); end
    endtask

    task automatic test_writeback();
        idle_inputs();
        core_state = `CORE_WRITEBACK; RegWrite = 1'b1; rd_address = 4'd3; WriteData = 8'hA5;
        tick();
        vectors++; if (ro_write_err !== 1'b0) begin errs++; $display("FAIL wb_free_roerr got %b want 0", ro_write_err); end
        request(4'd3, 4'd13);
        vectors++; if (rs !== 8'hA5) begin errs++; $display("FAIL wb_r3 got %h want a5", rs); end
        vectors++; if (rt !== 8'h09) begin errs++; $display("FAIL wb_r13_pre got %h want 09", rt); end
        idle_inputs();
        core_state = `CORE_WRITEBACK; RegWrite = 1'b1; rd_address = 4'd13; WriteData = 8'hFF;
        tick();
        vectors++; if (ro_write_err !== 1'b1) begin errs++; $display("FAIL ro_pulse got %b want 1", ro_write_err); end
        idle_inputs();
        tick();
        vectors++; if (ro_write_err !== 1'b0) begin errs++; $display("FAIL ro_pulse_end got %b want 0", ro_write_err); end
        request(4'd13, 4'd0);
        vectors++; if (rs !== 8'h09) begin errs++; $display("FAIL ro_r13_kept got %h want 09", rs); end
    endtask

    task automatic test_scoreboard();
        idle_inputs();
        ld_issue = 1'b1; rd_address = 4'd5;
        tick();
        vectors++; if (pending !== 16'h0020) begin errs++; $display("FAIL issue_pending got %h want 0020", pending); end
        request(4'd5, 4'd0);
        vectors++; if (stall !== 1'b1) begin errs++; $display("FAIL pend_stall got %b want 1", stall); end
        vectors++; if (rs !== 8'h00) begin errs++; $display("FAIL pend_rs got %h want 00", rs); end
        idle_inputs();
        enable = 1'b0; core_state = `CORE_REQUEST; rs_address = 4'd3;
        ld_done = 1'b1; ld_address = 4'd5; ld_data = 8'h3C;
        tick();
        vectors++; if (pending !== 16'h0000) begin errs++; $display("FAIL gated_lddone got %h want 0000", pending); end
        vectors++; if (stall !== 1'b1) begin errs++; $display("FAIL gated_stall_hold got %b want 1", stall); end
        vectors++; if (rs !== 8'h00) begin errs++; $display("FAIL gated_rs_hold got %h want 00", rs); end
        request(4'd5, 4'd0);
        vectors++; if (rs !== 8'h3C) begin errs++; $display("FAIL reissue_rs got %h want 3c", rs); end
        vectors++; if (stall !== 1'b0) begin errs++; $display("FAIL reissue_stall got %b want 0", stall); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        ld_issue = 1'b1; rd_address = 4'd5;
        tick();
        idle_inputs();
        core_state = `CORE_REQUEST; rs_address = 4'd5; rt_address = 4'd5;
        ld_done = 1'b1; ld_address = 4'd5; ld_data = 8'h77;
        tick();
        vectors++; if (rs !== 8'h77) begin errs++; $display("FAIL bypass_rs got %h want 77", rs); end
        vectors++; if (rt !== 8'h77) begin errs++; $display("FAIL bypass_rt got %h want 77", rt); end
        vectors++; if (stall !== 1'b0) begin errs++; $display("FAIL bypass_stall got %b want 0", stall); end
        vectors++; if (pending !== 16'h0000) begin errs++; $display("FAIL bypass_pending got %h want 0000", pending); end
    endtask

    task automatic test_collisions();
        idle_inputs();
        ld_issue = 1'b1; rd_address = 4'd6;
        tick();
        idle_inputs();
        core_state = `CORE_WRITEBACK; RegWrite = 1'b1; rd_address = 4'd6; WriteData = 8'h11;
        ld_done = 1'b1; ld_address = 4'd6; ld_data = 8'h22;
        tick();
        vectors++; if (pending !== 16'h0000) begin errs++; $display("FAIL wbld_pending got %h want 0000", pending); end
        request(4'd6, 4'd0);
        vectors++; if (rs !== 8'h11) begin errs++; $display("FAIL wbld_r6 got %h want 11", rs); end
        idle_inputs();
        ld_issue = 1'b1; rd_address = 4'd7; ld_done = 1'b1; ld_address = 4'd7; ld_data = 8'h5A;
        tick();
        vectors++; if (pending !== 16'h0080) begin errs++; $display("FAIL issdone_pending got %h want 0080", pending); end
        request(4'd7, 4'd3);
        vectors++; if (rs !== 8'h5A) begin errs++; $display("FAIL issdone_r7 got %h want 5a", rs); end
        vectors++; if (rt !== 8'hA5) begin errs++; $display("FAIL issdone_r3 got %h want a5", rt); end
        vectors++; if (stall !== 1'b1) begin errs++; $display("FAIL issdone_stall got %b want 1", stall); end
        idle_inputs();
        ld_done = 1'b1; ld_address = 4'd7; ld_data = 8'h5A;
        tick();
        idle_inputs();
        core_state = `CORE_WRITEBACK; RegWrite = 1'b1; rd_address = 4'd8; WriteData = 8'h81;
        ld_done = 1'b1; ld_address = 4'd9; ld_data = 8'h92;
        tick();
        request(4'd8, 4'd9);
        vectors++; if (rs !== 8'h81) begin errs++; $display("FAIL dual_r8 got %h want 81", rs); end
        vectors++; if (rt !== 8'h92) begin errs++; $display("FAIL dual_r9 got %h want 92", rt); end
        idle_inputs();
        ld_issue = 1'b1; rd_address = 4'd14;
        tick();
        vectors++; if (ro_write_err !== 1'b1) begin errs++; $display("FAIL ro_issue_err got %b want 1", ro_write_err); end
        vectors++; if (pending !== 16'h0000) begin errs++; $display("FAIL ro_issue_pending got %h want 0000", pending); end
        idle_inputs();
        enable = 1'b0; core_state = `CORE_WRITEBACK; RegWrite = 1'b1; rd_address = 4'd13; ld_issue = 1'b1;
        tick();
        vectors++; if (ro_write_err !== 1'b0) begin errs++; $display("FAIL gated_roerr got %b want 0", ro_write_err); end
    endtask

    task automatic test_reset_midflight();
        idle_inputs();
        core_state = `CORE_WRITEBACK; RegWrite = 1'b1; rd_address = 4'd4; WriteData = 8'h55;
        tick();
        idle_inputs(); ld_issue = 1'b1; rd_address = 4'd4; tick();
        idle_inputs(); ld_issue = 1'b1; rd_address = 4'd5; tick();
        request(4'd4, 4'd5);
        vectors++; if (pending !== 16'h0030) begin errs++; $display("FAIL pre_reset_pending got %h want 0030", pending); end
        vectors++; if (rs !== 8'h55) begin errs++; $display("FAIL pre_reset_rs got %h want 55", rs); end
        vectors++; if (stall !== 1'b1) begin errs++; $display("FAIL pre_reset_stall got %b want 1", stall); end
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++; if (pending !== 16'h0000) begin errs++; $display("FAIL mid_reset_pending got %h want 0000", pending); end
        vectors++; if (rs !== 8'h00) begin errs++; $display("FAIL mid_reset_rs got %h want 00", rs); end
        vectors++; if (stall !== 1'b0) begin errs++; $display("FAIL mid_reset_stall got %b want 0", stall); end
        request(4'd4, 4'd5);
        vectors++; if (rs !== 8'h00) begin errs++; $display("FAIL mid_reset_r4 got %h want 00", rs); end
        vectors++; if (rt !== 8'h00) begin errs++; $display("FAIL mid_reset_r5 got %h want 00", rt); end
    endtask

    task automatic test_wide();
        rs_w = 5'd31; rt_w = 5'd30; block_id_w = 16'hBEEF;
        request(4'd0, 4'd0);
        vectors++; if (rs_w_o !== 16'h012C) begin errs++; $display("FAIL wide_tid got %h want 012c", rs_w_o); end
        vectors++; if (rt_w_o !== 16'h0005) begin errs++; $display("FAIL wide_bdim got %h want 0005", rt_w_o); end
        rs_w = 5'd29;
        request(4'd0, 4'd0);
        vectors++; if (rs_w_o !== 16'hBEEF) begin errs++; $display("FAIL wide_bidx got %h want beef", rs_w_o); end
        vectors++; if (pending_w !== 32'h0) begin errs++; $display("FAIL wide_pending got %h want 0", pending_w); end
    endtask

    initial begin
        reset = 1'b1;
        block_id = 8'h09;
        block_id_w = '0; WriteData_w = '0; ld_data_w = '0;
        rd_w = '0; rs_w = '0; rt_w = '0; ld_addr_w = '0;
        RegWrite_w = 1'b0; ld_issue_w = 1'b0; ld_done_w = 1'b0;
        idle_inputs();
        test_reset();
        test_special_regs();
        test_writeback();
        test_scoreboard();
        test_bypass();
        test_collisions();
        test_reset_midflight();
        test_wide();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
